// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W_DEFAULT    = 8;
  localparam int INSTR_W_DEFAULT = 8;
  localparam int PC_LAST_DEFAULT = 15;

  // Opcode nibble (instr[7:4]) that stops fetching when HALT support is built in.
  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// Output slot plus one skid entry between the memory return path and the decoder.
module fetch_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         full
);

  logic         out_vld_reg;
  logic [W-1:0] out_data_reg;
  logic         sk_vld_reg;
  logic [W-1:0] sk_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
      sk_vld_reg   <= 1'b0;
      sk_data_reg  <= '0;
    end else if (flush) begin
      out_vld_reg <= 1'b0;
      sk_vld_reg  <= 1'b0;
    end else if (!out_vld_reg || out_ready) begin
      // Slot frees up: the skid entry is older than any arrival, so it goes first.
      if (sk_vld_reg) begin
        out_vld_reg  <= 1'b1;
        out_data_reg <= sk_data_reg;
        sk_vld_reg   <= 1'b0;
      end else begin
        out_vld_reg <= in_vld;
        if (in_vld) begin
          out_data_reg <= in_data;
        end
      end
    end else if (in_vld) begin
      sk_vld_reg  <= 1'b1;
      sk_data_reg <= in_data;
    end
  end

  assign out_vld  = out_vld_reg;
  assign out_data = out_data_reg;
  assign full     = sk_vld_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request tracking, branch redirect and optional HALT.
// Define FETCH_HALT_EN to stop fetching after an instruction whose top nibble is HALT_OP.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT,
  parameter int PC_LAST = PC_LAST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               br_vld,
  input  logic [PC_W-1:0]    br_target,
  output logic               dec_vld,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_LAST_V = PC_W'(PC_LAST);

  logic [PC_W-1:0] pc_reg, pc_next;
  logic            req_vld_reg, req_vld_next;
  logic [PC_W-1:0] req_pc_reg, req_pc_next;
  fetch_state_e    state_reg, state_next;

  logic arrive;
  logic halt_hit;
  logic skid_full;
  logic skid_busy;
  logic issue;
  logic [INSTR_W+PC_W-1:0] out_data;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return (p == PC_LAST_V) ? '0 : p + PC_W'(1);
  endfunction

  assign arrive = req_vld_reg && !br_vld;

`ifdef FETCH_HALT_EN
  assign halt_hit = arrive && (instr_i[7:4] == HALT_OP);
  assign halted   = (state_reg == HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // Hold off issue if the skid is occupied now or is about to take this cycle's arrival.
  assign skid_busy = skid_full || (arrive && dec_vld && !dec_ready);
  assign issue     = (state_reg == RUN) && !skid_busy && !br_vld && !halt_hit;

  always_comb begin
    pc_next      = pc_reg;
    req_vld_next = 1'b0;
    req_pc_next  = req_pc_reg;
    state_next   = state_reg;
    if (br_vld) begin
      pc_next    = br_target;
      state_next = RUN;
    end else if (halt_hit) begin
      pc_next    = pc_inc(req_pc_reg);
      state_next = HALT;
    end else if (issue) begin
      req_vld_next = 1'b1;
      req_pc_next  = pc_reg;
      pc_next      = pc_inc(pc_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= '0;
      req_vld_reg <= 1'b0;
      req_pc_reg  <= '0;
      state_reg   <= RUN;
    end else begin
      pc_reg      <= pc_next;
      req_vld_reg <= req_vld_next;
      req_pc_reg  <= req_pc_next;
      state_reg   <= state_next;
    end
  end

  assign pc_o = pc_reg;

  fetch_skid #(
    .W(INSTR_W + PC_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (br_vld),
    .in_vld   (arrive),
    .in_data  ({instr_i, req_pc_reg}),
    .out_ready(dec_ready),
    .out_vld  (dec_vld),
    .out_data (out_data),
    .full     (skid_full)
  );

  assign dec_instr = out_data[PC_W +: INSTR_W];
  assign dec_pc    = out_data[PC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: stream-order model plus directed timing checks.
module tb_fetch_unit;

  localparam int PC_LAST = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc_o;
  logic [7:0] instr_i;
  logic       br_vld;
  logic [7:0] br_target;
  logic       dec_vld;
  logic       dec_ready;
  logic [7:0] dec_instr;
  logic [7:0] dec_pc;
  logic       halted;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .PC_W   (8),
    .INSTR_W(8),
    .PC_LAST(PC_LAST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_o     (pc_o),
    .instr_i  (instr_i),
    .br_vld   (br_vld),
    .br_target(br_target),
    .dec_vld  (dec_vld),
    .dec_ready(dec_ready),
    .dec_instr(dec_instr),
    .dec_pc   (dec_pc),
    .halted   (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory with one-cycle registered read.
  always @(posedge clk) instr_i <= mem[pc_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] next_pc(input logic [7:0] p);
    return (p == 8'(PC_LAST)) ? 8'd0 : p + 8'd1;
  endfunction

  // Stream model: delivered PCs follow program order from 0 or the last branch target,
  // each instruction matches memory, and a stalled output holds still.
  logic [7:0] exp_pc;
  logic       hold_pend;
  logic [7:0] hold_pc, hold_instr;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc    = 8'd0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_vld", 32'(dec_vld), 32'd1);
        chk("hold_pc", 32'(dec_pc), 32'(hold_pc));
        chk("hold_instr", 32'(dec_instr), 32'(hold_instr));
      end
      if (dec_vld) chk("instr_vs_mem", 32'(dec_instr), 32'(mem[dec_pc]));
`ifndef FETCH_HALT_EN
      chk("halted_tied0", 32'(halted), 32'd0);
`endif
      if (dec_vld && dec_ready) begin
        chk("seq_pc", 32'(dec_pc), 32'(exp_pc));
        exp_pc = next_pc(dec_pc);
      end
      if (br_vld) exp_pc = br_target;
      hold_pend  = dec_vld && !dec_ready && !br_vld;
      hold_pc    = dec_pc;
      hold_instr = dec_instr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_dec(input string name, input logic [7:0] pc, input logic [7:0] instr);
    chk({name, "_vld"}, 32'(dec_vld), 32'd1);
    chk({name, "_pc"}, 32'(dec_pc), 32'(pc));
    chk({name, "_instr"}, 32'(dec_instr), 32'(instr));
    $display("txn %s: pc=%0h instr=%0h", name, dec_pc, dec_instr);
  endtask

  task automatic do_branch(input string name, input logic [7:0] target);
    br_vld    = 1'b1;
    br_target = target;
    tick();
    br_vld    = 1'b0;
    dec_ready = 1'b1;
    chk({name, "_bubble1"}, 32'(dec_vld), 32'd0);
    tick();
    chk({name, "_bubble2"}, 32'(dec_vld), 32'd0);
    tick();
    expect_dec(name, target, mem[target]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 5) & 8'h7F;
    mem[0] = 8'h16;
    mem[1] = 8'h2B;
    mem[2] = 8'h31;
    mem[3] = 8'hF0;

    rst_n     = 1'b0;
    br_vld    = 1'b0;
    br_target = 8'd0;
    dec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pc_o", 32'(pc_o), 32'd0);
    chk("rst_dec_vld", 32'(dec_vld), 32'd0);
    chk("rst_dec_instr", 32'(dec_instr), 32'd0);
    chk("rst_dec_pc", 32'(dec_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Release; the next rising edge is E0.
    rst_n = 1'b1;
    tick();
    chk("e0_dec_vld", 32'(dec_vld), 32'd0);
    chk("e0_pc_o", 32'(pc_o), 32'd1);
    tick();
    expect_dec("e1", 8'd0, 8'h16);
    tick();
    expect_dec("e2", 8'd1, 8'h2B);
    tick();
    expect_dec("e3", 8'd2, 8'h31);
    tick();
    expect_dec("e4", 8'd3, 8'hF0);
`ifdef FETCH_HALT_EN
    chk("halt_set", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_no_vld", 32'(dec_vld), 32'd0);
      chk("halt_stays", 32'(halted), 32'd1);
    end
    br_vld    = 1'b1;
    br_target = 8'd0;
    tick();
    br_vld = 1'b0;
    chk("halt_clear", 32'(halted), 32'd0);
    tick();
    tick();
    expect_dec("halt_resume", 8'd0, 8'h16);
`else
    chk("haltop_ordinary", 32'(halted), 32'd0);
    tick();
    expect_dec("e5", 8'd4, mem[4]);
`endif

    // Back-pressure: three stalled cycles, then skid drains with one bubble.
    do_branch("br6", 8'd6);
    tick();
    expect_dec("bp_pre", 8'd7, mem[7]);
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_dec("bp_frozen", 8'd7, mem[7]);
    end
    dec_ready = 1'b1;
    tick();
    expect_dec("bp_drain", 8'd8, mem[8]);
    tick();
    chk("bp_bubble", 32'(dec_vld), 32'd0);
    tick();
    expect_dec("bp_resume", 8'd9, mem[9]);
    tick();
    expect_dec("bp_next", 8'd10, mem[10]);

    // Branch while output slot and skid are both occupied.
    dec_ready = 1'b0;
    tick();
    expect_dec("full_hold", 8'd10, mem[10]);
    do_branch("br5_full", 8'd5);
    tick();
    expect_dec("br5_next", 8'd6, mem[6]);

    // Wrap at PC_LAST.
    do_branch("br14", 8'd14);
    tick();
    expect_dec("wrap15", 8'd15, mem[15]);
    tick();
    expect_dec("wrap0", 8'd0, 8'h16);
    tick();
    expect_dec("wrap1", 8'd1, 8'h2B);

    // Target above PC_LAST increments through the full range.
    do_branch("brfe", 8'hFE);
    tick();
    expect_dec("hi_ff", 8'hFF, mem[8'hFF]);
    tick();
    expect_dec("hi_00", 8'h00, 8'h16);

    // Asynchronous reset between clock edges.
    chk("pre_arst_vld", 32'(dec_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_dec_vld", 32'(dec_vld), 32'd0);
    chk("arst_pc_o", 32'(pc_o), 32'd0);
    chk("arst_dec_pc", 32'(dec_pc), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_e0_vld", 32'(dec_vld), 32'd0);
    tick();
    expect_dec("arst_e1", 8'd0, 8'h16);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
